// File: rtl/pc_sequencer_if.sv
// Purpose: fetch-control bundle between hazard/EX/ID control and the PC sequencer.
// Signals:
//   fetch_stall                 hazard unit holds fetch
//   branch_valid/zero/addr      EX-stage branch resolution and target
//   jump_valid/addr             ID-stage jump resolution and target
//   pc, pc_plus4                current fetch address and its sequential successor
//   fetch_valid, flush          fetch qualifier and IF/ID squash
//   misalign                    accepted redirect target had nonzero low bits
// master: control side that drives requests; slave: the sequencer.
interface pc_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              fetch_stall;
    logic              branch_valid;
    logic              branch_zero;
    logic [ADDR_W-1:0] branch_addr;
    logic              jump_valid;
    logic [ADDR_W-1:0] jump_addr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              fetch_valid;
    logic              flush;
    logic              misalign;

    modport master (
        output fetch_stall, branch_valid, branch_zero, branch_addr,
               jump_valid, jump_addr,
        input  pc, pc_plus4, fetch_valid, flush, misalign
    );

    modport slave (
        input  fetch_stall, branch_valid, branch_zero, branch_addr,
               jump_valid, jump_addr,
        output pc, pc_plus4, fetch_valid, flush, misalign
    );
endinterface

// File: rtl/pc_sequencer.sv
// Purpose: owns the program counter and selects the next fetch address among
// PC+4, a taken branch target and a jump target, holding a redirect that
// resolves while fetch is stalled until the stall releases.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pc_sequencer_if.slave (stall/branch/jump in; pc, pc_plus4,
//          fetch_valid, flush, misalign out)
module pc_sequencer #(
    parameter int unsigned      ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;

    logic              take_br;
    logic              redir;
    logic [ADDR_W-1:0] target_raw;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_plus4;
    logic              fetch_valid;
    logic              flush;
    logic              misalign;

    // Redirect decode: the branch is the older instruction, so it wins over a jump.
    always_comb begin
        take_br    = bus.branch_valid & bus.branch_zero;
        redir      = take_br | bus.jump_valid;
        target_raw = take_br ? bus.branch_addr : bus.jump_addr;
        target     = {target_raw[ADDR_W-1:2], 2'b00};
    end

    assign pc_plus4 = pc_q + ADDR_W'(4);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // PC and pending-redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            pend_q <= '0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redir && bus.fetch_stall) begin
                    pend_d  = target;
                    state_d = ST_HOLD;
                end else if (redir) begin
                    pc_d = target;
                end else if (!bus.fetch_stall) begin
                    pc_d = pc_plus4;
                end
            end
            ST_HOLD: begin
                // Newest redirect replaces the pending one; no +4 step while holding.
                if (redir && bus.fetch_stall) begin
                    pend_d = target;
                end else if (redir) begin
                    pc_d    = target;
                    state_d = ST_RUN;
                end else if (!bus.fetch_stall) begin
                    pc_d    = pend_q;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Output decode; a redirect is only accepted in RUN or HOLD.
    always_comb begin
        fetch_valid = 1'b0;
        flush       = 1'b0;
        misalign    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                fetch_valid = 1'b1;
                flush       = redir;
                misalign    = redir & (target_raw[1:0] != 2'b00);
            end
            ST_HOLD: begin
                flush    = redir;
                misalign = redir & (target_raw[1:0] != 2'b00);
            end
            default: begin
                fetch_valid = 1'b0;
            end
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = fetch_valid;
    assign bus.flush       = flush;
    assign bus.misalign    = misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose: self-checking bench for pc_sequencer: directed scenarios plus a
// randomized run checked against a behavioural next-PC model.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(
        .ADDR_W  (32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: current pc, whether we are in the boot cycle,
    // and whether a redirect is waiting for the stall to release.
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_boot;
    bit          m_pending;

    function automatic bit m_taken();
        return bus.branch_valid && bus.branch_zero;
    endfunction

    function automatic bit m_redir();
        return m_taken() || bus.jump_valid;
    endfunction

    function automatic logic [31:0] m_raw();
        return m_taken() ? bus.branch_addr : bus.jump_addr;
    endfunction

    function automatic logic [31:0] m_target();
        return m_raw() & ~32'h3;
    endfunction

    task automatic model_reset();
        m_pc      = RST_PC;
        m_pend    = '0;
        m_boot    = 1'b1;
        m_pending = 1'b0;
    endtask

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_redir()) begin
            if (bus.fetch_stall) begin
                m_pending = 1'b1;
                m_pend    = m_target();
            end else begin
                m_pc      = m_target();
                m_pending = 1'b0;
            end
        end else if (!bus.fetch_stall) begin
            if (m_pending) begin
                m_pc      = m_pend;
                m_pending = 1'b0;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.fetch_stall  = 1'b0;
        bus.branch_valid = 1'b0;
        bus.branch_zero  = 1'b0;
        bus.branch_addr  = '0;
        bus.jump_valid   = 1'b0;
        bus.jump_addr    = '0;
    endtask

    // Move the pc to a known address with an unstalled jump.
    task automatic goto(input logic [31:0] addr);
        clear_inputs();
        bus.jump_valid = 1'b1;
        bus.jump_addr  = addr;
        #1;
        tick();
        clear_inputs();
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n          = 1'b0;
        bus.jump_valid = 1'b1;
        bus.jump_addr  = 32'h0000_0003;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.pc !== RST_PC) begin errors++; $display("FAIL rst_pc: got %h exp %h", bus.pc, RST_PC); end
        checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_fv: got %b exp 0", bus.fetch_valid); end
        checks++; if (bus.flush !== 1'b0 || bus.misalign !== 1'b0) begin errors++; $display("FAIL rst_flush_mis: got %b%b exp 00", bus.flush, bus.misalign); end
        clear_inputs();
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if (bus.pc !== 32'h100 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL boot: got pc=%h fv=%b exp pc=100 fv=0", bus.pc, bus.fetch_valid); end
        tick();
        checks++; if (bus.pc !== 32'h100 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL run0: got pc=%h fv=%b exp pc=100 fv=1", bus.pc, bus.fetch_valid); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (bus.pc !== 32'h100 + 32'(4 * i) || bus.fetch_valid !== 1'b1 || bus.flush !== 1'b0) begin
                errors++;
                $display("FAIL seq%0d: got pc=%h fv=%b fl=%b exp pc=%h fv=1 fl=0", i, bus.pc, bus.fetch_valid, bus.flush, 32'h100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_branch();
        goto(32'h200);
        checks++; if (bus.pc !== 32'h200) begin errors++; $display("FAIL br_setup: got %h exp 200", bus.pc); end
        bus.branch_valid = 1'b1;
        bus.branch_zero  = 1'b1;
        bus.branch_addr  = 32'h400;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL br_taken_flush: got %b exp 1", bus.flush); end
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.pc !== 32'h400) begin errors++; $display("FAIL br_taken_pc: got %h exp 400", bus.pc); end
        goto(32'h200);
        bus.branch_valid = 1'b1;
        bus.branch_zero  = 1'b0;
        bus.branch_addr  = 32'h402;
        #1;
        checks++; if (bus.flush !== 1'b0 || bus.misalign !== 1'b0) begin errors++; $display("FAIL br_nt_flush: got fl=%b mis=%b exp 0 0", bus.flush, bus.misalign); end
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.pc !== 32'h204) begin errors++; $display("FAIL br_nt_pc: got %h exp 204", bus.pc); end
    endtask

    task automatic test_branch_vs_jump();
        goto(32'h200);
        bus.branch_valid = 1'b1;
        bus.branch_zero  = 1'b1;
        bus.branch_addr  = 32'h800;
        bus.jump_valid   = 1'b1;
        bus.jump_addr    = 32'h900;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL bj_flush: got %b exp 1", bus.flush); end
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.pc !== 32'h800) begin errors++; $display("FAIL bj_pc: got %h exp 800", bus.pc); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL bj_single: got %b exp 0", bus.flush); end
    endtask

    task automatic test_stall_hold();
        goto(32'h300);
        bus.fetch_stall = 1'b1;
        bus.jump_valid  = 1'b1;
        bus.jump_addr   = 32'h500;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL hold_flush: got %b exp 1", bus.flush); end
        tick();
        bus.jump_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.pc !== 32'h300 || bus.fetch_valid !== 1'b0 || bus.flush !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: got pc=%h fv=%b fl=%b exp pc=300 fv=0 fl=0", i, bus.pc, bus.fetch_valid, bus.flush);
            end
            tick();
        end
        bus.jump_valid = 1'b1;
        bus.jump_addr  = 32'h600;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL hold_reflush: got %b exp 1", bus.flush); end
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.pc !== 32'h300 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL hold_pre: got pc=%h fv=%b exp pc=300 fv=0", bus.pc, bus.fetch_valid); end
        tick();
        checks++; if (bus.pc !== 32'h600 || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL hold_release: got pc=%h fv=%b exp pc=600 fv=1", bus.pc, bus.fetch_valid); end
    endtask

    task automatic test_wrap_misalign();
        goto(32'hFFFF_FFFC);
        checks++; if (bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_p4: got %h exp 0", bus.pc_plus4); end
        tick();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h exp 0", bus.pc); end
        bus.jump_valid = 1'b1;
        bus.jump_addr  = 32'h0000_0702;
        #1;
        checks++; if (bus.misalign !== 1'b1 || bus.flush !== 1'b1) begin errors++; $display("FAIL mis_flag: got mis=%b fl=%b exp 1 1", bus.misalign, bus.flush); end
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.pc !== 32'h700 || bus.misalign !== 1'b0) begin errors++; $display("FAIL mis_pc: got pc=%h mis=%b exp pc=700 mis=0", bus.pc, bus.misalign); end
    endtask

    task automatic test_reset_mid();
        goto(32'h300);
        bus.fetch_stall = 1'b1;
        bus.jump_valid  = 1'b1;
        bus.jump_addr   = 32'h500;
        #1;
        tick();
        bus.jump_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        bus.jump_valid = 1'b1;
        bus.jump_addr  = 32'h504;
        model_reset();
        #1;
        checks++; if (bus.pc !== RST_PC || bus.fetch_valid !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL mid_rst: got pc=%h fv=%b fl=%b exp pc=%h fv=0 fl=0", bus.pc, bus.fetch_valid, bus.flush, RST_PC); end
        tick();
        clear_inputs();
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if (bus.pc !== RST_PC || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL mid_boot: got pc=%h fv=%b exp pc=%h fv=0", bus.pc, bus.fetch_valid, RST_PC); end
        tick();
        checks++; if (bus.pc !== RST_PC || bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL mid_run: got pc=%h fv=%b exp pc=%h fv=1", bus.pc, bus.fetch_valid, RST_PC); end
        tick();
        checks++; if (bus.pc !== RST_PC + 32'd4 || bus.pc === 32'h500) begin errors++; $display("FAIL mid_noreplay: got %h exp %h", bus.pc, RST_PC + 32'd4); end
    endtask

    task automatic test_random();
        logic [31:0] e_pc;
        logic [31:0] e_p4;
        logic        e_fv;
        logic        e_fl;
        logic        e_mis;
        for (int n = 0; n < 400; n++) begin
            bus.fetch_stall  = ($urandom_range(0, 9) < 4);
            bus.branch_valid = ($urandom_range(0, 9) < 3);
            bus.branch_zero  = $urandom_range(0, 1) == 1;
            bus.branch_addr  = $urandom;
            bus.jump_valid   = ($urandom_range(0, 9) < 2);
            bus.jump_addr    = $urandom;
            #1;
            e_pc  = m_pc;
            e_p4  = m_pc + 32'd4;
            e_fv  = !m_boot && !m_pending;
            e_fl  = !m_boot && m_redir();
            e_mis = e_fl && (m_raw() & 32'h3) != 32'h0;
            checks++;
            if (bus.pc !== e_pc || bus.pc_plus4 !== e_p4) begin
                errors++;
                $display("FAIL rnd_pc[%0d]: got pc=%h p4=%h exp pc=%h p4=%h", n, bus.pc, bus.pc_plus4, e_pc, e_p4);
            end
            checks++;
            if (bus.fetch_valid !== e_fv || bus.flush !== e_fl || bus.misalign !== e_mis) begin
                errors++;
                $display("FAIL rnd_ctl[%0d]: got fv/fl/mis=%b%b%b exp %b%b%b", n, bus.fetch_valid, bus.flush, bus.misalign, e_fv, e_fl, e_mis);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_branch();
        test_branch_vs_jump();
        test_stall_hold();
        test_wrap_misalign();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
